serv_rf_ram_if: RTL and testbench
=================================

Name: serv_rf_ram_if

Overview:
- Parametrised bridge between the bit-serial core datapath and a W-bit-wide simple-dual-port RAM that holds the register file, plus optional CSR shadow registers.
- Core side: two serial read ports (rs1/rs2) and two serial write ports (rd/csr), LSB first, 32 bits each.
- RAM side: one synchronous read port and one write port.
- Generalises the fixed 1-bit register file by supporting multiple widths, extra registers, two write ports, and read prefetch.

Parameters:
- WIDTH, 2, RAM word width in bits; legal values 2, 4, 8, 16, 32.
- CSR_REGS, 4, extra registers above x31; legal values 0 or 4.
- RAW, $clog2(32+CSR_REGS), register address width (derived).
- AW, RAW+$clog2(32/WIDTH), RAM address width (derived).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rreq  in  1  read start pulse
- i_rreg0  in  RAW  rs1 register
- i_rreg1  in  RAW  rs2 register
- o_ready  out  1  one-cycle pulse: read bit 0 on o_rdata0/1
- o_rdata0  out  1  rs1 serial data
- o_rdata1  out  1  rs2 serial data
- i_wreq  in  1  write start pulse, coincident with write bit 0
- i_wen0  in  1  port0 write enable, sampled at i_wreq
- i_wen1  in  1  port1 write enable, sampled at i_wreq
- i_wreg0  in  RAW  port0 register, sampled at i_wreq
- i_wreg1  in  RAW  port1 register, sampled at i_wreq
- i_wdata0  in  1  port0 serial data
- i_wdata1  in  1  port1 serial data
- o_raddr  out  AW  RAM read address {reg,chunk}
- o_ren  out  1  RAM read enable
- i_rdata  in  WIDTH  RAM read data, valid the cycle after o_ren
- o_waddr  out  AW  RAM write address {reg,chunk}
- o_wdata  out  WIDTH  RAM write data; bit 0 is the earliest serial bit
- o_wen  out  1  RAM write enable

Behaviour:
- Reset (async, i_rst_n=0):
  - o_ready, o_ren, o_wen, o_rdata0, o_rdata1 are 0; both sequencers go idle.
  - A transfer in progress is aborted; no RAM write issues after reset asserts.
- Layout: register r, chunk n (n=0..32/WIDTH-1) holds bits [n·WIDTH+WIDTH-1 : n·WIDTH] at address {r,n}.
- Read, T0 = cycle i_rreq is accepted:
  - Registers are latched at T0.
  - rs1 chunk n is addressed at T0+n·WIDTH; rs2 chunk n at T0+n·WIDTH+1. o_ren is high only in those cycles.
  - o_ready is high at T0+3 only.
  - Bit k of both operands drives o_rdata0/1 during T0+3+k, k=0..31; both outputs are registered.
  - If the register is 0, its read data is forced to 0 regardless of RAM contents; o_ren still pulses.
  - Outputs are 0 outside the data window.
- Write, T0 = cycle i_wreq is accepted:
  - Serial bit k is sampled at T0+k.
  - Chunk n is written for port0 at T0+(n+1)·WIDTH and for port1 one cycle later; the last write is at T0+33.
  - A separate hold register keeps port1 data while the next chunk shifts in.
  - o_wen stays low for a port whose enable was 0 or whose register is 0.
  - If both ports target the same register, both writes issue; port1 lands last and wins.
- Busy rules:
  - i_rreq is ignored from T0+1 through T0+34 of an active read.
  - i_wreq is ignored from T0+1 through T0+31 of an active write; back-to-back writes from T0+32 are legal.
  - Reads and writes run fully concurrently.
  - Reading a register during the same-numbered register's write window returns undefined data; this is a core protocol violation and is excluded from checks.
- Chunk counters wrap at 32/WIDTH. WIDTH=32 yields one read pair and one write pair per transfer.

Test Plan:
- WIDTH=4, CSR_REGS=4, RAM preloaded x5=0xDEADBEEF and x7=0x12345678; i_rreq with rreg0=5, rreg1=7 → o_ready at T0+3; o_rdata0 serialises 0xDEADBEEF and o_rdata1 serialises 0x12345678, LSB first, over T0+3..T0+34; o_raddr sequence is {5,0},{7,0} at T0,T0+1 then {5,1},{7,1} at T0+4,T0+5.
- Write port0 x3=0xA5A5A5A5 and port1 CSR reg 33=0x0000FFFF → 8 writes per port; o_wdata=0x5 at o_waddr={3,0} at T0+4, and 0xF at {33,0} at T0+5; last write at T0+33.
- Write x0=0xFFFFFFFF with wen0=1 → o_wen never high for reg 0. Read x0 with RAM garbage preloaded → o_rdata0 all 0.
- Both write ports target x9 with 0x1 and 0x2 → subsequent read returns 0x00000002.
- Deassert i_rst_n at T0+10 of a write → o_wen is 0 immediately and stays 0; a fresh read afterwards works normally.
- Sweep WIDTH=2,8,32 with random register contents and concurrent reads/writes to distinct registers → data matches a scoreboard model; i_wreq at T0+32 is accepted back-to-back.

Source files
------------

// File: rtl/serv_rf_ram_if.sv
// serv_rf_ram_if
// Bridges the bit-serial core register-file ports to a WIDTH-bit simple
// dual-port RAM. The RAM holds x0..x31 plus optional CSR shadow registers.
// Register r, chunk n holds bits [n*WIDTH +: WIDTH] at RAM address {r,n}.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_rreq, i_rreg0/1      read start pulse and rs1/rs2 register numbers
//   o_ready                one-cycle pulse: bit 0 of both operands is on o_rdata0/1
//   o_rdata0/1             registered serial operands, LSB first, 32 bits
//   i_wreq                 write start pulse, coincident with serial bit 0
//   i_wen0/1, i_wreg0/1    per-port enable and register, sampled at i_wreq
//   i_wdata0/1             serial write data, LSB first
//   o_raddr, o_ren, i_rdata   RAM read port (data one cycle after o_ren)
//   o_waddr, o_wdata, o_wen   RAM write port
//
// Handshake: there is no back-pressure. i_rreq / i_wreq are single-cycle
// start pulses accepted only when the matching sequencer is idle (a write may
// also restart in the cycle of its own last port0 chunk); a pulse arriving
// while busy is dropped. Reads and writes run concurrently.
module serv_rf_ram_if #(
  parameter int WIDTH    = 2,
  parameter int CSR_REGS = 4,
  parameter int RAW      = $clog2(32 + CSR_REGS),
  parameter int AW       = RAW + $clog2(32 / WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  input  logic [RAW-1:0]   i_rreg0,
  input  logic [RAW-1:0]   i_rreg1,
  output logic             o_ready,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic             i_wreq,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [RAW-1:0]   i_wreg0,
  input  logic [RAW-1:0]   i_wreg1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen
);

  localparam int         LW = $clog2(WIDTH);
  localparam logic [5:0] W6 = 6'(WIDTH);
  localparam logic [5:0] WM = 6'(WIDTH - 1);

  // ---------------------------------------------------------------- read
  // rcnt is the cycle offset from the accepted request; rt reads as 0 in
  // the accept cycle itself so chunk 0 of rs1 can be addressed at once.
  logic             rbusy;
  logic [5:0]       rcnt;
  logic [5:0]       rt;
  logic             rstart;
  logic [RAW-1:0]   rreg0_q, rreg1_q, rsel;
  logic             rz0, rz1;
  logic             ren0, ren1;
  logic             rd0_q, rd1_q;
  logic [WIDTH-1:0] rsr0, rsr1;
  logic             rdata0_q, rdata1_q;
  logic             rwin;

  assign rstart = i_rreq & ~rbusy;
  assign rt     = rbusy ? rcnt : 6'd0;
  // rs1 chunks on offsets == 0 mod WIDTH, rs2 chunks one cycle later
  assign ren0   = (rstart | rbusy) && (rt < 6'd32) && ((rt & WM) == 6'd0);
  assign ren1   = rbusy && (rt < 6'd32) && ((rt & WM) == 6'd1);
  assign rsel   = ren1 ? rreg1_q : (rbusy ? rreg0_q : i_rreg0);
  // {reg, offset} >> log2(WIDTH) gives {reg, chunk}; the rs2 +1 drops out
  assign o_raddr = AW'({rsel, rt[4:0]} >> LW);
  assign o_ren   = ren0 | ren1;
  assign o_ready = rbusy && (rcnt == 6'd3);
  // output registers load bit k at offset 2+k, so it shows at offset 3+k
  assign rwin    = rbusy && (rcnt >= 6'd2) && (rcnt <= 6'd33);
  assign o_rdata0 = rdata0_q;
  assign o_rdata1 = rdata1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbusy    <= 1'b0;
      rcnt     <= 6'd0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      rz0      <= 1'b0;
      rz1      <= 1'b0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      rsr0     <= '0;
      rsr1     <= '0;
      rdata0_q <= 1'b0;
      rdata1_q <= 1'b0;
    end else begin
      if (rstart) begin
        rbusy   <= 1'b1;
        rcnt    <= 6'd1;
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
        rz0     <= (i_rreg0 == '0);
        rz1     <= (i_rreg1 == '0);
      end else if (rbusy) begin
        if (rcnt == 6'd34) rbusy <= 1'b0;
        rcnt <= rcnt + 6'd1;
      end
      rd0_q <= ren0;
      rd1_q <= ren1;
      // rs1 data arrives one cycle before its first bit is needed: buffer it
      if (rd0_q) rsr0 <= rz0 ? '0 : i_rdata;
      else       rsr0 <= rsr0 >> 1;
      rdata0_q <= rwin & rsr0[0];
      // rs2 data arrives exactly when its first bit is needed: bypass bit 0
      if (rd1_q) begin
        rdata1_q <= rwin & ~rz1 & i_rdata[0];
        rsr1     <= rz1 ? '0 : (i_rdata >> 1);
      end else begin
        rdata1_q <= rwin & rsr1[0];
        rsr1     <= rsr1 >> 1;
      end
    end
  end

  // --------------------------------------------------------------- write
  logic             wbusy;
  logic [5:0]       wcnt;
  logic             wstart;
  logic [RAW-1:0]   wreg0_q, wreg1_q;
  logic             we0_q, we1_q;
  logic [WIDTH-1:0] wsr0, wsr1, whold1;
  logic             wp0;
  logic [4:0]       wsub;
  logic [AW-1:0]    waddr0, waddr1_next, whaddr1;
  logic             w1_pend, w1_en;

  // a new write may start in the cycle the previous one issues its last
  // port0 chunk; that chunk still uses the old registered state
  assign wstart = i_wreq & (~wbusy | (wcnt == 6'd32));
  assign wp0    = wbusy && (wcnt >= W6) && ((wcnt & WM) == 6'd0);
  assign wsub   = 5'(wcnt - W6);
  assign waddr0      = AW'({wreg0_q, wsub} >> LW);
  assign waddr1_next = AW'({wreg1_q, wsub} >> LW);
  // port0 and port1 writes never fall in the same cycle
  assign o_wen   = (wp0 & we0_q) | (w1_pend & w1_en);
  assign o_waddr = w1_pend ? whaddr1 : waddr0;
  assign o_wdata = w1_pend ? whold1 : wsr0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wbusy   <= 1'b0;
      wcnt    <= 6'd0;
      wreg0_q <= '0;
      wreg1_q <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      wsr0    <= '0;
      wsr1    <= '0;
      whold1  <= '0;
      whaddr1 <= '0;
      w1_pend <= 1'b0;
      w1_en   <= 1'b0;
    end else begin
      // free-running shifters: after WIDTH shifts bit 0 holds the earliest bit
      wsr0 <= {i_wdata0, wsr0[WIDTH-1:1]};
      wsr1 <= {i_wdata1, wsr1[WIDTH-1:1]};
      if (wstart) begin
        wbusy   <= 1'b1;
        wcnt    <= 6'd1;
        wreg0_q <= i_wreg0;
        wreg1_q <= i_wreg1;
        we0_q   <= i_wen0 && (i_wreg0 != '0);
        we1_q   <= i_wen1 && (i_wreg1 != '0);
      end else if (wbusy) begin
        if (wcnt == 6'd32) wbusy <= 1'b0;
        wcnt <= wcnt + 6'd1;
      end
      // port1 chunk is parked while the shifter moves on to the next chunk
      w1_pend <= wp0;
      if (wp0) begin
        whold1  <= wsr1;
        whaddr1 <= waddr1_next;
        w1_en   <= we1_q;
      end
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_if.sv
// Bench for serv_rf_ram_if: four instances (WIDTH 2, 4, 8, 32) share one
// stimulus stream, each with its own RAM model. The WIDTH=4 instance also
// exposes its RAM bus for cycle-exact address/data checks.
module tb_serv_rf_ram_if;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rreq = 1'b0, wreq = 1'b0;
  logic [5:0] rreg0 = '0, rreg1 = '0, wreg0 = '0, wreg1 = '0;
  logic       wen0 = 1'b0, wen1 = 1'b0, wdata0 = 1'b0, wdata1 = 1'b0;
  logic       preload = 1'b0;
  logic [31:0] img   [36];
  logic [31:0] model [36];

  logic [3:0] ready_v, rd0_v, rd1_v, wen_v;
  logic       obs_ren, obs_wen;
  logic [8:0] obs_raddr, obs_waddr;
  logic [3:0] obs_wdata;

  int errs = 0;
  int checks = 0;
  logic [18:0] exp_q[$];

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W   = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    localparam int NC  = 32 / W;
    localparam int AWL = 6 + $clog2(NC);
    logic [AWL-1:0] ra, wa;
    logic [W-1:0]   rdat, wdat;
    logic           ren, wen, rdy, d0, d1;
    logic [W-1:0]   mem [2**AWL];
    int zwr = 0;

    serv_rf_ram_if #(.WIDTH(W), .CSR_REGS(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_rreg0(rreg0), .i_rreg1(rreg1),
      .o_ready(rdy), .o_rdata0(d0), .o_rdata1(d1), .i_wreq(wreq),
      .i_wen0(wen0), .i_wen1(wen1), .i_wreg0(wreg0), .i_wreg1(wreg1),
      .i_wdata0(wdata0), .i_wdata1(wdata1), .o_raddr(ra), .o_ren(ren),
      .i_rdata(rdat), .o_waddr(wa), .o_wdata(wdat), .o_wen(wen));

    always @(posedge clk) begin
      if (preload) begin
        for (int r = 0; r < 36; r++)
          for (int n = 0; n < NC; n++)
            mem[AWL'(r * NC + n)] <= img[r][n*W +: W];
      end else if (wen) begin
        mem[wa] <= wdat;
      end
      if (ren) rdat <= mem[ra];
      if (wen && (wa[AWL-1 -: 6] == 6'd0)) zwr <= zwr + 1;
    end

    assign ready_v[g] = rdy;
    assign rd0_v[g]   = d0;
    assign rd1_v[g]   = d1;
    assign wen_v[g]   = wen;

    if (W == 4) begin : obs
      assign obs_ren   = ren;
      assign obs_raddr = ra;
      assign obs_wen   = wen;
      assign obs_waddr = wa;
      assign obs_wdata = wdat;
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_of(input logic [5:0] r);
    return (r == 6'd0) ? 32'h0 : model[r];
  endfunction

  // ------------------------------------------------------ driver tasks
  task automatic preload_img();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int r = 0; r < 36; r++) model[r] = img[r];
  endtask

  task automatic drive_write(input bit e0, input bit e1, input logic [5:0] r0,
                             input logic [5:0] r1, input logic [31:0] d0, input logic [31:0] d1);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      wreq = (k == 0);
      if (k == 0) begin
        wen0 = e0; wen1 = e1; wreg0 = r0; wreg1 = r1;
      end else if (k == 1) begin
        // must not matter: sampled only with i_wreq
        wen0 = ~e0; wen1 = ~e1; wreg0 = r0 ^ 6'd1; wreg1 = r1 ^ 6'd2;
      end
      wdata0 = d0[k];
      wdata1 = d1[k];
    end
    if (e0 && r0 != 6'd0) model[r0] = d0;
    if (e1 && r1 != 6'd0) model[r1] = d1;
  endtask

  // poke re-pulses i_rreq inside the busy window, which must be ignored
  task automatic drive_read(input logic [5:0] r0, input logic [5:0] r1, input bit poke,
                            input logic [31:0] e0, input logic [31:0] e1);
    logic b0, b1;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      rreq  = (k == 0) || (poke && (k == 20 || k == 34));
      rreg0 = (k == 0) ? r0 : 6'(k);
      rreg1 = (k == 0) ? r1 : 6'(35 - k);
      @(negedge clk);
      b0 = (k >= 3 && k <= 34) ? e0[k-3] : 1'b0;
      b1 = (k >= 3 && k <= 34) ? e1[k-3] : 1'b0;
      check($sformatf("ready r%0d/r%0d k=%0d", r0, r1, k), 32'(ready_v), (k == 3) ? 32'hF : 32'h0);
      check($sformatf("rdata0 r%0d k=%0d", r0, k), 32'(rd0_v), {28'h0, {4{b0}}});
      check($sformatf("rdata1 r%0d k=%0d", r1, k), 32'(rd1_v), {28'h0, {4{b1}}});
    end
  endtask

  // scoreboard on the WIDTH=4 RAM bus: entries are {offset, addr, data}
  task automatic mon_bus(input bit wr, input int ncyc);
    logic [18:0] e, a;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); @(negedge clk);
      if (wr ? obs_wen : obs_ren) begin
        a = wr ? {6'(k), obs_waddr, obs_wdata} : {6'(k), obs_raddr, 4'h0};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check($sformatf("%s bus k=%0d", wr ? "wr" : "rd", k), 32'(a), 32'(e));
      end
    end
    check(wr ? "wr bus left" : "rd bus left", 32'(exp_q.size()), 32'h0);
  endtask

  // -------------------------------------------------------- test vectors
  typedef struct {
    logic        e0, e1;
    logic [5:0]  wr0, wr1;
    logic [31:0] d0, d1;
    logic [5:0]  rr0, rr1;
    logic [31:0] x0, x1;
  } vec_t;
  vec_t vecs[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] va, vb, x0, x1;
    logic [31:0] da, db, dc, dd;
    logic [5:0]  a0, a1, b0, b1, q0, q1;
    int tot;

    vecs[0] = '{1'b0, 1'b0, 6'd3,  6'd33, 32'h0,        32'h0,        6'd3,  6'd33, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[1] = '{1'b1, 1'b0, 6'd0,  6'd4,  32'hFFFFFFFF, 32'h12121212, 6'd0,  6'd4,  32'h00000000, 32'h0BAD0004};
    vecs[2] = '{1'b1, 1'b1, 6'd9,  6'd9,  32'h00000001, 32'h00000002, 6'd9,  6'd9,  32'h00000002, 32'h00000002};
    vecs[3] = '{1'b1, 1'b1, 6'd35, 6'd31, 32'h80000001, 32'h7FFFFFFE, 6'd35, 6'd31, 32'h80000001, 32'h7FFFFFFE};
    vecs[4] = '{1'b1, 1'b1, 6'd10, 6'd0,  32'hCAFEF00D, 32'hFFFFFFFF, 6'd10, 6'd0,  32'hCAFEF00D, 32'h00000000};

    for (int r = 0; r < 36; r++) img[r] = 32'h0BAD0000 | 32'(r);
    img[0] = 32'hFFFFFFFF;
    img[5] = 32'hDEADBEEF;
    img[7] = 32'h12345678;

    // reset state
    repeat (2) begin
      @(negedge clk);
      check("reset ready", 32'(ready_v), 32'h0);
      check("reset rdata0", 32'(rd0_v), 32'h0);
      check("reset rdata1", 32'(rd1_v), 32'h0);
      check("reset wen", 32'(wen_v), 32'h0);
      check("reset ren", 32'(obs_ren), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    preload_img();

    // read x5/x7 with bus scoreboard and ignored re-requests
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back({6'(4 * n),     6'd5, 3'(n), 4'h0});
      exp_q.push_back({6'(4 * n + 1), 6'd7, 3'(n), 4'h0});
    end
    fork
      drive_read(6'd5, 6'd7, 1'b1, 32'hDEADBEEF, 32'h12345678);
      mon_bus(1'b0, 36);
    join

    // x0 over RAM garbage reads as zero
    drive_read(6'd0, 6'd5, 1'b0, 32'h0, 32'hDEADBEEF);

    // dual-port write x3 / CSR 33 with bus scoreboard
    va = 32'hA5A5A5A5;
    vb = 32'h0000FFFF;
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back({6'(4 * (n + 1)),     6'd3,  3'(n), va[4*n +: 4]});
      exp_q.push_back({6'(4 * (n + 1) + 1), 6'd33, 3'(n), vb[4*n +: 4]});
    end
    fork
      drive_write(1'b1, 1'b1, 6'd3, 6'd33, va, vb);
      mon_bus(1'b1, 36);
    join

    // table: write then read back
    for (int i = 0; i < 5; i++) begin
      drive_write(vecs[i].e0, vecs[i].e1, vecs[i].wr0, vecs[i].wr1, vecs[i].d0, vecs[i].d1);
      repeat (3) @(posedge clk);
      drive_read(vecs[i].rr0, vecs[i].rr1, 1'b0, vecs[i].x0, vecs[i].x1);
    end
    tot = gi[0].zwr + gi[1].zwr + gi[2].zwr + gi[3].zwr;
    check("writes to x0", 32'(tot), 32'h0);

    // reset at T0+10 of a write aborts it
    fork
      drive_write(1'b1, 1'b0, 6'd12, 6'd0, 32'hFFFFFFFF, 32'h0);
      begin
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("wen at reset", 32'(wen_v), 32'h0);
        for (int k = 0; k < 24; k++) begin
          @(negedge clk);
          check($sformatf("wen after reset k=%0d", k), 32'(wen_v), 32'h0);
          check($sformatf("ready in reset k=%0d", k), 32'(ready_v), 32'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    drive_read(6'd5, 6'd7, 1'b0, exp_of(6'd5), exp_of(6'd7));

    // concurrent reads and back-to-back writes on distinct registers
    for (int it = 0; it < 3; it++) begin
      a0 = 6'(16 + 4 * it); a1 = 6'(17 + 4 * it);
      b0 = 6'(18 + 4 * it); b1 = 6'(19 + 4 * it);
      q0 = (it == 0) ? 6'd5 : 6'(12 + 4 * it);
      q1 = (it == 0) ? 6'd7 : 6'(15 + 4 * it);
      da = $urandom; db = $urandom; dc = $urandom; dd = $urandom;
      x0 = exp_of(q0);
      x1 = exp_of(q1);
      fork
        begin
          drive_write(1'b1, 1'b1, a0, a1, da, db);
          drive_write(1'b1, 1'b1, b0, b1, dc, dd);
        end
        begin
          repeat ($urandom_range(0, 12)) @(posedge clk);
          drive_read(q0, q1, 1'b0, x0, x1);
        end
      join
      repeat (3) @(posedge clk);
      drive_read(a0, b1, 1'b0, exp_of(a0), exp_of(b1));
      drive_read(a1, b0, 1'b0, exp_of(a1), exp_of(b0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
